// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: IF/ID record layout, fetch constants and
// small address helpers used by the fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_WORDS = 32'd32;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    // Word index of addr compared against the number of implemented words.
    function automatic logic pc_in_range(input logic [31:0] addr, input logic [31:0] words);
        return ({2'b00, addr[31:2]} < words);
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Clear drops only the valid bit; the payload is
// kept so a flushed slot never glitches instr/pc.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    if_id_t q_r;

    // IF/ID storage with clear > load > hold priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r.valid <= 1'b0;
            q_r.instr <= 32'h0000_0000;
            q_r.pc    <= 32'h0000_0000;
        end else if (clear) begin
            q_r.valid <= 1'b0;
            q_r.instr <= q_r.instr;
            q_r.pc    <= q_r.pc;
        end else if (load) begin
            q_r.valid <= 1'b1;
            q_r.instr <= load_instr;
            q_r.pc    <= load_pc;
        end else begin
            q_r <= q_r;
        end
    end

    assign valid = q_r.valid;
    assign instr = q_r.instr;
    assign pc    = q_r.pc;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, range check, redirect handling,
// sticky error flags and IF/ID handshake counter.
module ifetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    output logic        fetch_fault,
    output logic [31:0] retire_cnt
);

    localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

    logic [31:0] pc_r;
    logic        misalign_err_r;
    logic        fetch_fault_r;
    logic [31:0] retire_cnt_r;

    logic        adv_s;
    logic        load_s;
    logic        in_range_s;
    logic        retire_s;
    logic [31:0] fetch_instr_s;

    assign adv_s      = !id_valid || id_ready;
    assign load_s     = !redirect_valid && adv_s;
    assign in_range_s = pc_in_range(pc_r, IMEM_WORDS_W);
    assign retire_s   = id_valid && id_ready;

    // Out-of-range fetches are replaced by a NOP rather than forwarding garbage.
    always_comb begin
        fetch_instr_s = NOP_INSTR;
        if (in_range_s) begin
            fetch_instr_s = imem_data;
        end else begin
            fetch_instr_s = NOP_INSTR;
        end
    end

    // Program counter: redirect beats advance; hold keeps imem_addr stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= align_word(redirect_pc);
        end else if (adv_s) begin
            pc_r <= pc_r + 32'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_r <= 1'b0;
            fetch_fault_r  <= 1'b0;
        end else begin
            if (redirect_valid && is_misaligned(redirect_pc)) begin
                misalign_err_r <= 1'b1;
            end else begin
                misalign_err_r <= misalign_err_r;
            end
            if (load_s && !in_range_s) begin
                fetch_fault_r <= 1'b1;
            end else begin
                fetch_fault_r <= fetch_fault_r;
            end
        end
    end

    // Handshake counter; a handshake coinciding with a flush still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= 32'd0;
        end else if (retire_s) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .clear      (redirect_valid),
        .load_instr (fetch_instr_s),
        .load_pc    (pc_r),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc)
    );

    assign imem_addr    = pc_r;
    assign misalign_err = misalign_err_r;
    assign fetch_fault  = fetch_fault_r;
    assign retire_cnt   = retire_cnt_r;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed vector tables, an async reset
// check and a randomized run against a behavioural model.
module tb_ifetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic        fetch_fault;
    logic [31:0] retire_cnt;

    logic [31:0] mem [0:31];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[6:2]];

    ifetch #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err),
        .fetch_fault    (fetch_fault),
        .retire_cnt     (retire_cnt)
    );

    typedef struct packed {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
        logic        e_mis;
        logic        e_fault;
    } vec_t;

    vec_t va [4];
    vec_t vb [14];

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_valid, m_mis, m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, " id_instr"}, id_instr, 32'h0000_0000);
        chk({tag, " id_pc"}, id_pc, 32'h0000_0000);
        chk({tag, " imem_addr"}, imem_addr, 32'h0000_0000);
        chk({tag, " misalign_err"}, {31'd0, misalign_err}, 32'd0);
        chk({tag, " fetch_fault"}, {31'd0, fetch_fault}, 32'd0);
        chk({tag, " retire_cnt"}, retire_cnt, 32'd0);
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        string n;
        id_ready       = v.ready;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        @(posedge clk);
        #1;
        n = $sformatf("%s[%0d]", tag, idx);
        chk({n, " id_valid"}, {31'd0, id_valid}, {31'd0, v.e_valid});
        if (v.e_valid) begin
            chk({n, " id_instr"}, id_instr, v.e_instr);
            chk({n, " id_pc"}, id_pc, v.e_pc);
        end
        chk({n, " imem_addr"}, imem_addr, v.e_addr);
        chk({n, " retire_cnt"}, retire_cnt, v.e_cnt);
        chk({n, " misalign_err"}, {31'd0, misalign_err}, {31'd0, v.e_mis});
        chk({n, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, v.e_fault});
        @(negedge clk);
    endtask

    // Next state of the model from the spec rules, given this cycle's inputs.
    task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
        int unsigned word;
        if (m_valid && rdy) m_cnt = m_cnt + 32'd1;
        if (rv) begin
            m_valid = 1'b0;
            m_pc    = rpc - (rpc % 32'd4);
            if ((rpc % 32'd4) != 32'd0) m_mis = 1'b1;
        end else if (!m_valid || rdy) begin
            word = m_pc / 32'd4;
            if (word < 32) begin
                m_instr = mem[word];
            end else begin
                m_instr = 32'h0000_0013;
                m_fault = 1'b1;
            end
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic        r_rdy, r_rv;
        logic [31:0] r_pc;
        int unsigned sel;
        string       n;

        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        mem[2] = 32'h0000_0033;
        mem[3] = 32'h0000_0044;

        //          rdy   rv    rpc           valid instr          pc            addr          cnt   mis   fault
        va[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0011, 32'h0000_0000, 32'h0000_0004, 32'd0, 1'b0, 1'b0};
        va[1] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 32'h0000_0004, 32'h0000_0008, 32'd1, 1'b0, 1'b0};
        va[2] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0033, 32'h0000_0008, 32'h0000_000C, 32'd2, 1'b0, 1'b0};
        va[3] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0044, 32'h0000_000C, 32'h0000_0010, 32'd3, 1'b0, 1'b0};

        vb[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0011, 32'h0000_0000, 32'h0000_0004, 32'd0, 1'b0, 1'b0};
        vb[1]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 32'h0000_0004, 32'h0000_0008, 32'd1, 1'b0, 1'b0};
        vb[2]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 32'h0000_0004, 32'h0000_0008, 32'd1, 1'b0, 1'b0};
        vb[3]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 32'h0000_0004, 32'h0000_0008, 32'd1, 1'b0, 1'b0};
        vb[4]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0022, 32'h0000_0004, 32'h0000_0008, 32'd1, 1'b0, 1'b0};
        vb[5]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0033, 32'h0000_0008, 32'h0000_000C, 32'd2, 1'b0, 1'b0};
        vb[6]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0044, 32'h0000_000C, 32'h0000_0010, 32'd3, 1'b0, 1'b0};
        vb[7]  = '{1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0040, 32'd3, 1'b0, 1'b0};
        vb[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0010, 32'h0000_0040, 32'h0000_0044, 32'd3, 1'b0, 1'b0};
        vb[9]  = '{1'b1, 1'b1, 32'h0000_0046, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0044, 32'd4, 1'b1, 1'b0};
        vb[10] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0011, 32'h0000_0044, 32'h0000_0048, 32'd4, 1'b1, 1'b0};
        vb[11] = '{1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0080, 32'd5, 1'b1, 1'b0};
        vb[12] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0013, 32'h0000_0080, 32'h0000_0084, 32'd5, 1'b1, 1'b1};
        vb[13] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0013, 32'h0000_0084, 32'h0000_0088, 32'd6, 1'b1, 1'b1};

        do_reset();
        check_reset_values("reset");
        for (int i = 0; i < 4; i++) apply(va[i], "stream", i);

        do_reset();
        for (int i = 0; i < 14; i++) apply(vb[i], "stall_redir", i);

        // Async reset in the middle of a stall, between clock edges.
        id_ready = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model
        m_pc = 32'h0000_0000; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0; m_fault = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            sel   = $urandom_range(0, 9);
            if (sel < 6)      r_pc = 32'($urandom_range(0, 35)) * 32'd4;
            else if (sel < 9) r_pc = 32'($urandom_range(0, 35)) * 32'd4 + 32'($urandom_range(1, 3));
            else              r_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            if (i < 150 && sel >= 6 && sel < 9) r_pc = r_pc & 32'hFFFF_FFFC;
            id_ready       = r_rdy;
            redirect_valid = r_rv;
            redirect_pc    = r_pc;
            model_step(r_rdy, r_rv, r_pc);
            @(posedge clk);
            #1;
            n = $sformatf("rand[%0d]", i);
            chk({n, " id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
            chk({n, " id_instr"}, id_instr, m_instr);
            chk({n, " id_pc"}, id_pc, m_ipc);
            chk({n, " imem_addr"}, imem_addr, m_pc);
            chk({n, " retire_cnt"}, retire_cnt, m_cnt);
            chk({n, " misalign_err"}, {31'd0, misalign_err}, {31'd0, m_mis});
            chk({n, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, m_fault});
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
